ram_port_arbiter: RTL and testbench

//  Shares the single-port byte RAM of the UART collector among N_REQ requesters:

---
 rtl/ram_port_arbiter_if.sv | 17 +
 rtl/ram_port_arbiter.sv | 64 ++++++
 tb/tb_ram_port_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side and RAM-side signals of ram_port_arbiter
interface ram_port_arbiter_if #(
  parameter int N_REQ  = 20,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
);
  logic [N_REQ-1:0]        i_req, i_we, o_gnt, o_rvalid;
  logic [N_REQ*ADDR_W-1:0] i_addr;
  logic [N_REQ*DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0]       o_rdata, o_D, i_D;
  logic [ADDR_W-1:0]       o_addr;
  logic                    WE, RE;
  modport slave  (input  i_req, i_we, i_addr, i_wdata, i_D,
                  output o_gnt, o_rvalid, o_rdata, o_addr, o_D, WE, RE);
  modport master (output i_req, i_we, i_addr, i_wdata, i_D,
                  input  o_gnt, o_rvalid, o_rdata, o_addr, o_D, WE, RE);
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one byte RAM among N_REQ requesters; RAM_ARB_WPRIO_EN adds write priority with forced reads
module ram_port_arbiter #(
  parameter int N_REQ  = 20,
  parameter int ADDR_W = 14,
`ifdef RAM_ARB_WPRIO_EN
  parameter int MAX_WSTREAK = 4,
`else
`endif
  parameter int DATA_W = 8
) (
  input logic               i_clk,
  input logic               i_rst,
  ram_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  logic [PW-1:0]    ptr, win;
  logic             hit;
  logic [N_REQ-1:0] mask;
  // downward scan so the last hit kept is the nearest one at or after p
  function automatic logic [PW:0] pick(input logic [N_REQ-1:0] m, input logic [PW-1:0] p);
    logic [PW:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin : scan
      int j;
      j = int'(p) + i;
      j = (j >= N_REQ) ? j - N_REQ : j;
      if (m[j]) r = {1'b1, j[PW-1:0]};
    end
    return r;
  endfunction
`ifdef RAM_ARB_WPRIO_EN
  localparam int SW = $clog2(MAX_WSTREAK + 1);
  logic [SW-1:0]    wstreak;
  logic [N_REQ-1:0] wr_req, rd_req;
  logic             wr_gnt;
  assign wr_req = bus.i_req & bus.i_we;
  assign rd_req = bus.i_req & ~bus.i_we;
  assign wr_gnt = hit & bus.i_we[win];
  assign mask = (wstreak == SW'(MAX_WSTREAK) && |rd_req) ? rd_req : |wr_req ? wr_req : bus.i_req;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) wstreak <= '0;
    else if (!wr_gnt) wstreak <= '0;
    else if (wstreak != SW'(MAX_WSTREAK)) wstreak <= wstreak + 1'b1;
  end
`else
  assign mask = bus.i_req;
`endif
  assign {hit, win}   = pick(mask, ptr);
  assign bus.o_gnt    = hit ? {{(N_REQ-1){1'b0}}, 1'b1} << win : '0;
  assign bus.WE       = hit & bus.i_we[win];
  assign bus.RE       = hit & ~bus.i_we[win];
  assign bus.o_addr   = hit ? bus.i_addr[int'(win)*ADDR_W +: ADDR_W] : '0;
  assign bus.o_D      = hit ? bus.i_wdata[int'(win)*DATA_W +: DATA_W] : '0;
  assign bus.o_rdata  = bus.i_D;
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ptr          <= '0;
      bus.o_rvalid <= '0;
    end else begin
      if (hit) ptr <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
      bus.o_rvalid <= bus.RE ? bus.o_gnt : '0;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed and random checks of ram_port_arbiter against a queue-based reference model
module tb_ram_port_arbiter;
  localparam int N = 20, AW = 14, DW = 8;
  logic i_clk = 1'b0, i_rst = 1'b0;
  always #5 i_clk = ~i_clk;
  ram_port_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  bit [DW-1:0] ram [2**AW];
  bit [DW-1:0] exp_mem [2**AW];
  always @(posedge i_clk) begin
    if (bus.WE) ram[bus.o_addr] <= bus.o_D;
    if (bus.RE) bus.i_D <= ram[bus.o_addr];
  end
  bit rq [N], wq [N];
  logic [AW-1:0] aq [N];
  logic [DW-1:0] dq [N];
  int mptr = 0, mstreak = 0, ev_who = -1, mode = 0, checks = 0, errors = 0;
  logic [DW-1:0] ev_data;
  logic [N-1:0] g;
  int w;
  int pat [$];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] oh(input int k);
    return 32'(1) << k;
  endfunction
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      bus.i_req[k] = rq[k];
      bus.i_we[k] = wq[k];
      bus.i_addr[k*AW +: AW] = aq[k];
      bus.i_wdata[k*DW +: DW] = dq[k];
    end
  endtask
  task automatic new_req(input int k);
    rq[k] = ($urandom_range(0, 1) == 1);
    wq[k] = (k < 10);
    aq[k] = AW'((k % 10) * 1024 + $urandom_range(0, 15));
    dq[k] = DW'($urandom);
  endtask
  function automatic int model_pick();
    int q [$];
    bit anyw = 0, anyr = 0;
    for (int k = 0; k < N; k++) begin
      if (rq[k] && wq[k]) anyw = 1;
      if (rq[k] && !wq[k]) anyr = 1;
    end
    for (int off = 0; off < N; off++) begin : rot
      int k;
      k = (mptr + off) % N;
      if (!rq[k]) continue;
`ifdef RAM_ARB_WPRIO_EN
      if ((mstreak >= 4 && anyr) ? wq[k] : (anyw && !wq[k])) continue;
`else
`endif
      q.push_back(k);
    end
    return (q.size() > 0) ? q[0] : -1;
  endfunction
  task automatic model_reset();
    mptr = 0;
    mstreak = 0;
    ev_who = -1;
  endtask
  task automatic cycle(output int wn, output logic [N-1:0] gn);
    logic [N-1:0] exp_rv;
    int nw;
    drive();
    @(negedge i_clk);
    wn = model_pick();
    gn = bus.o_gnt;
    chk("gnt", bus.o_gnt, (wn >= 0) ? oh(wn) : 0);
    chk("we", bus.WE, (wn >= 0 && wq[wn]) ? 1 : 0);
    chk("re", bus.RE, (wn >= 0 && !wq[wn]) ? 1 : 0);
    chk("addr", bus.o_addr, (wn >= 0) ? aq[wn] : 0);
    chk("wdata", bus.o_D, (wn >= 0) ? dq[wn] : 0);
    exp_rv = '0;
    if (ev_who >= 0) exp_rv[ev_who] = 1'b1;
    chk("rvalid", bus.o_rvalid, exp_rv);
    if (ev_who >= 0) chk("rdata", bus.o_rdata, ev_data);
    @(posedge i_clk);
    nw = -1;
    if (wn < 0) mstreak = 0;
    else begin
      if (wq[wn]) begin
        exp_mem[aq[wn]] = dq[wn];
        mstreak++;
      end else begin
        nw = wn;
        ev_data = exp_mem[aq[wn]];
        mstreak = 0;
      end
      mptr = (wn + 1) % N;
    end
    ev_who = nw;
    #1;
    if (mode == 1)
      for (int k = 0; k < N; k++) if (k == wn || !rq[k]) new_req(k);
  endtask
  task automatic do_reset();
    for (int k = 0; k < N; k++) rq[k] = 0;
    drive();
    i_rst = 1'b0;
    #1;
    chk("rst_rvalid", bus.o_rvalid, 0);
    @(negedge i_clk);
    chk("rst_gnt", bus.o_gnt, 0);
    chk("rst_rvalid2", bus.o_rvalid, 0);
    model_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      rq[k] = 0; wq[k] = 0; aq[k] = '0; dq[k] = '0;
    end
    do_reset();
    repeat (10) cycle(w, g);
    for (int k = 0; k < N; k++) begin
      rq[k] = 1; wq[k] = 0; aq[k] = AW'((k % 10) * 1024 + k);
    end
    for (int i = 0; i <= N; i++) begin
      cycle(w, g);
      chk("rr_seq", g, oh(i % N));
    end
    for (int k = 0; k < N; k++) rq[k] = 0;
    rq[3] = 1; wq[3] = 1; aq[3] = 14'h0C05; dq[3] = 8'hA5;
    cycle(w, g);
    chk("wr3_gnt", g, oh(3));
    rq[3] = 0;
    rq[2] = 1; rq[4] = 1; wq[2] = 0; wq[4] = 0; aq[4] = 14'h0C05;
    cycle(w, g);
    chk("ptr4", g, oh(4));
    rq[2] = 0; rq[4] = 0;
    rq[18] = 1;
    cycle(w, g);
    rq[18] = 0; rq[19] = 1; rq[0] = 1;
    cycle(w, g); chk("wrap19a", g, oh(19));
    cycle(w, g); chk("wrap0", g, oh(0));
    cycle(w, g); chk("wrap19b", g, oh(19));
    for (int k = 0; k < N; k++) rq[k] = 0;
    rq[15] = 1; wq[15] = 0;
    cycle(w, g);
    chk("pre_rst_gnt", g, oh(15));
    do_reset();
    rq[5] = 1; rq[15] = 1; wq[5] = 0; wq[15] = 0;
    cycle(w, g);
    chk("post_rst", g, oh(5));
    do_reset();
    for (int k = 0; k < 10; k++) begin
      rq[k] = 1; wq[k] = 1; aq[k] = AW'(k * 1024 + 7); dq[k] = DW'(k + 8'h30);
    end
    rq[12] = 1; wq[12] = 0; aq[12] = AW'(2 * 1024 + 7);
`ifdef RAM_ARB_WPRIO_EN
    pat = '{0, 1, 2, 3, 12};
`else
    pat = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 12};
`endif
    for (int i = 0; i < 22; i++) begin
      cycle(w, g);
      chk("wprio_seq", g, oh(pat[i % pat.size()]));
    end
    for (int k = 0; k < N; k++) new_req(k);
    mode = 1;
    repeat (600) cycle(w, g);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
